// File: rtl/fanout_fork_pkg.sv
// Shared defaults and types for the fanout fork broadcast stage.
package fanout_fork_pkg;

  localparam int FANOUT_NUM_OUT_DEF = 7;
  localparam int FANOUT_DATA_W_DEF  = 17;
  localparam int FANOUT_PERF_W_DEF  = 16;

  typedef logic [FANOUT_NUM_OUT_DEF-1:0] branch_mask_t;

endpackage

// File: rtl/fanout_stall_cnt.sv
// Saturating stall counter with synchronous clear, used by fanout_fork_buf
// when FANOUT_FORK_PERF_CNT_EN is defined.
module fanout_stall_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fanout_fork_buf.sv
// Eager-fork broadcast stage: single-entry buffer feeding NUM_OUT branches.
// Optional stall counter port under FANOUT_FORK_PERF_CNT_EN.
module fanout_fork_buf
  import fanout_fork_pkg::*;
#(
  parameter int NUM_OUT    = FANOUT_NUM_OUT_DEF,
  parameter int DATA_WIDTH = FANOUT_DATA_W_DEF,
  parameter int PERF_WIDTH = FANOUT_PERF_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready
`ifdef FANOUT_FORK_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cnt
`endif
);

  logic                  full;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_OUT-1:0]    pending;
  logic [NUM_OUT-1:0]    hs;
  logic                  retire;
  logic                  acc;

  always_comb begin
    out_valid = {NUM_OUT{full}} & pending;
    out_data  = data_q;
    hs        = out_valid & out_ready;
    retire    = full & ((pending & ~hs) == '0);
    // flush blocks upstream so the clearing edge never coincides with a load
    in_ready  = ~flush & (~full | retire);
    acc       = in_valid & in_ready & (cfg_en != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      pending <= '0;
      data_q  <= '0;
    end else if (flush) begin
      full    <= 1'b0;
      pending <= '0;
    end else if (acc) begin
      full    <= 1'b1;
      pending <= cfg_en;
      data_q  <= in_data;
    end else if (retire) begin
      full    <= 1'b0;
      pending <= '0;
    end else begin
      pending <= pending & ~hs;
    end
  end

`ifdef FANOUT_FORK_PERF_CNT_EN
  fanout_stall_cnt #(
    .WIDTH(PERF_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .inc  (full & ~retire),
    .cnt  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fanout_fork_buf.sv
// Directed table-driven bench for fanout_fork_buf (NUM_OUT=3, DATA_WIDTH=8).
module tb_fanout_fork_buf;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] cfg_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
`ifdef FANOUT_FORK_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fanout_fork_buf #(
    .NUM_OUT   (3),
    .DATA_WIDTH(8),
    .PERF_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .cfg_en   (cfg_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FANOUT_FORK_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic [2:0]  cfg;
    logic [2:0]  rdy;
    logic        fl;
    logic        ir;
    logic [2:0]  ov;
    logic [7:0]  od;
    logic [15:0] st;
  } vec_t;

  localparam int NVEC = 31;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // v, d, cfg, rdy, fl | ir, ov, od, stall
    // broadcast, all ready: 5 tokens back to back
    tbl[0]  = '{1'b1, 8'h01, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'h00, 16'd0};
    tbl[1]  = '{1'b1, 8'h02, 3'b111, 3'b111, 1'b0, 1'b1, 3'b111, 8'h01, 16'd0};
    tbl[2]  = '{1'b1, 8'h03, 3'b111, 3'b111, 1'b0, 1'b1, 3'b111, 8'h02, 16'd0};
    tbl[3]  = '{1'b1, 8'h04, 3'b111, 3'b111, 1'b0, 1'b1, 3'b111, 8'h03, 16'd0};
    tbl[4]  = '{1'b1, 8'h05, 3'b111, 3'b111, 1'b0, 1'b1, 3'b111, 8'h04, 16'd0};
    tbl[5]  = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b111, 8'h05, 16'd0};
    tbl[6]  = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'h05, 16'd0};
    // staggered acceptance of 0xAA
    tbl[7]  = '{1'b1, 8'hAA, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 8'h05, 16'd0};
    tbl[8]  = '{1'b0, 8'h00, 3'b111, 3'b001, 1'b0, 1'b0, 3'b111, 8'hAA, 16'd0};
    tbl[9]  = '{1'b0, 8'h00, 3'b111, 3'b010, 1'b0, 1'b0, 3'b110, 8'hAA, 16'd1};
    tbl[10] = '{1'b0, 8'h00, 3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 8'hAA, 16'd2};
    tbl[11] = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'hAA, 16'd2};
    // branch 1 masked and never ready
    tbl[12] = '{1'b1, 8'h11, 3'b101, 3'b101, 1'b0, 1'b1, 3'b000, 8'hAA, 16'd2};
    tbl[13] = '{1'b1, 8'h22, 3'b101, 3'b101, 1'b0, 1'b1, 3'b101, 8'h11, 16'd2};
    tbl[14] = '{1'b1, 8'h33, 3'b101, 3'b101, 1'b0, 1'b1, 3'b101, 8'h22, 16'd2};
    tbl[15] = '{1'b0, 8'h00, 3'b101, 3'b101, 1'b0, 1'b1, 3'b101, 8'h33, 16'd2};
    // sink mode
    tbl[16] = '{1'b1, 8'h44, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    tbl[17] = '{1'b1, 8'h45, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    tbl[18] = '{1'b1, 8'h46, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    tbl[19] = '{1'b1, 8'h47, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    tbl[20] = '{1'b0, 8'h00, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    // mask captured at accept; cfg change applies to the next token
    tbl[21] = '{1'b1, 8'h3C, 3'b011, 3'b000, 1'b0, 1'b1, 3'b000, 8'h33, 16'd2};
    tbl[22] = '{1'b0, 8'h00, 3'b100, 3'b000, 1'b0, 1'b0, 3'b011, 8'h3C, 16'd2};
    tbl[23] = '{1'b1, 8'h5A, 3'b100, 3'b100, 1'b0, 1'b0, 3'b011, 8'h3C, 16'd3};
    tbl[24] = '{1'b1, 8'h5A, 3'b100, 3'b011, 1'b0, 1'b1, 3'b011, 8'h3C, 16'd4};
    tbl[25] = '{1'b0, 8'h00, 3'b100, 3'b111, 1'b0, 1'b1, 3'b100, 8'h5A, 16'd4};
    tbl[26] = '{1'b0, 8'h00, 3'b100, 3'b111, 1'b0, 1'b1, 3'b000, 8'h5A, 16'd4};
    // hold then flush
    tbl[27] = '{1'b1, 8'h66, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 8'h5A, 16'd4};
    tbl[28] = '{1'b0, 8'h00, 3'b111, 3'b000, 1'b0, 1'b0, 3'b111, 8'h66, 16'd4};
    tbl[29] = '{1'b1, 8'h77, 3'b111, 3'b000, 1'b1, 1'b0, 3'b111, 8'h66, 16'd5};
    tbl[30] = '{1'b0, 8'h00, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 8'h66, 16'd0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    cfg_en    = 3'b000;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 3'b000;
    #12;
    chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_out_data",  0, 32'(out_data),  32'h0);
    chk("rst_in_ready",  0, 32'(in_ready),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      cfg_en    = tbl[i].cfg;
      out_ready = tbl[i].rdy;
      flush     = tbl[i].fl;
      #1;
      chk("in_ready",  i, 32'(in_ready),  32'(tbl[i].ir));
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ov));
      chk("out_data",  i, 32'(out_data),  32'(tbl[i].od));
`ifdef FANOUT_FORK_PERF_CNT_EN
      chk("stall_cnt", i, 32'(stall_cnt), 32'(tbl[i].st));
`endif
      @(posedge clk);
    end

    // asynchronous reset while a token is held
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h99;
    cfg_en    = 3'b111;
    out_ready = 3'b000;
    flush     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_hold_valid", 0, 32'(out_valid), 32'h7);
    chk("mid_hold_data",  0, 32'(out_data),  32'h99);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, 32'(out_valid), 32'h0);
    chk("async_rst_ready", 0, 32'(in_ready),  32'h1);
    chk("async_rst_data",  0, 32'(out_data),  32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 3'b111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_valid", 0, 32'(out_valid), 32'h7);
    chk("post_rst_data",  0, 32'(out_data),  32'h55);
    chk("post_rst_ready", 0, 32'(in_ready),  32'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_drain", 0, 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
